// File: rtl/tmds_decoder_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_decoder_aligner_if
//  Purpose  : Symbol/decoded-data bundle for one TMDS receive channel.
//             master = deserializer/consumer side, slave = decoder/aligner.
//  Revision : 1.0  initial release
// ============================================================================
interface tmds_decoder_aligner_if;
  logic [9:0] tmdsWord;
  logic       bitSlip;
  logic       locked;
  logic [3:0] slipCount;
  logic [7:0] dataOut;
  logic [1:0] ctlOut;
  logic       deOut;

  modport master (
    output tmdsWord,
    input  bitSlip, locked, slipCount, dataOut, ctlOut, deOut
  );

  modport slave (
    input  tmdsWord,
    output bitSlip, locked, slipCount, dataOut, ctlOut, deOut
  );
endinterface
`default_nettype wire

// File: rtl/tmds_decoder_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_decoder_aligner
//  Purpose  : TMDS (DVI) channel receiver. Hunts for the 10-bit symbol
//             boundary by bit-slipping until a run of control tokens is seen,
//             then decodes symbols into pixel data, control bits and DE.
//  Revision : 1.0  initial release
// ============================================================================
module tmds_decoder_aligner #(
  parameter int SEARCH_CYCLES = 1024,
  parameter int TOKEN_RUN     = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOSS_CYCLES   = 4096
) (
  input  wire                   pixelClock,
  input  wire                   resetN,
  tmds_decoder_aligner_if.slave tmds
);

  localparam int WIN_MAX = (LOSS_CYCLES > SEARCH_CYCLES) ? LOSS_CYCLES : SEARCH_CYCLES;
  localparam int WIN_W   = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;
  localparam int RUN_W   = $clog2(TOKEN_RUN + 1);
  localparam int SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [WIN_W-1:0] SEARCH_LAST = WIN_W'(SEARCH_CYCLES - 1);
  localparam logic [WIN_W-1:0] LOSS_LAST   = WIN_W'(LOSS_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(TOKEN_RUN);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t           state_q,   state_d;
  logic [RUN_W-1:0] run_q,     run_d;
  logic [WIN_W-1:0] win_q,     win_d;
  logic [SET_W-1:0] settle_q,  settle_d;
  logic [3:0]       slip_q,    slip_d;
  logic             bitslip_q, bitslip_d;
  logic             locked_q,  locked_d;
  logic [7:0]       data_q,    data_d;
  logic [1:0]       ctl_q,     ctl_d;
  logic             de_q,      de_d;

  logic             is_token;
  logic [1:0]       token_code;
  logic [7:0]       q_bits;
  logic [7:0]       dec_data;
  logic [RUN_W-1:0] run_upd;
  logic             run_hit;

  // Control-token recognition on the raw symbol.
  always_comb begin
    is_token   = 1'b1;
    token_code = 2'b00;
    case (tmds.tmdsWord)
      10'b1101010100: token_code = 2'b00;
      10'b0010101011: token_code = 2'b01;
      10'b0101010100: token_code = 2'b10;
      10'b1010101011: token_code = 2'b11;
      default:        is_token   = 1'b0;
    endcase
  end

  // TMDS data decode: undo optional inversion, then undo XOR/XNOR chaining.
  always_comb begin
    dec_data    = '0;
    q_bits      = tmds.tmdsWord[9] ? ~tmds.tmdsWord[7:0] : tmds.tmdsWord[7:0];
    dec_data[0] = q_bits[0];
    for (int i = 1; i < 8; i++) begin
      dec_data[i] = tmds.tmdsWord[8] ? (q_bits[i] ^ q_bits[i-1])
                                     : ~(q_bits[i] ^ q_bits[i-1]);
    end
  end

  // Token run length as it would be after this word; a hit is the lock/refresh event.
  always_comb begin
    if (!is_token) begin
      run_upd = '0;
    end else if (run_q == RUN_FULL) begin
      run_upd = run_q;
    end else begin
      run_upd = run_q + RUN_W'(1);
    end
    run_hit = (run_upd == RUN_FULL);
  end

  // Alignment FSM next-state, counters and the decoded-output next values.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    win_d    = win_q;
    settle_d = settle_q;
    slip_d   = slip_q;

    case (state_q)
      ST_SEARCH: begin
        run_d = run_upd;
        // A completed token run takes priority over an expiring window.
        if (run_hit) begin
          state_d = ST_LOCKED;
          win_d   = '0;
        end else if (win_q == SEARCH_LAST) begin
          state_d = ST_SLIP;
          win_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_SLIP: begin
        run_d    = '0;
        settle_d = '0;
        slip_d   = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Words here still carry the old boundary; ignore them entirely.
        run_d = '0;
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SEARCH;
          settle_d = '0;
          win_d    = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default: begin // ST_LOCKED
        run_d = run_upd;
        // A refresh in the expiry cycle keeps lock.
        if (run_hit) begin
          win_d = '0;
        end else if (win_q == LOSS_LAST) begin
          state_d = ST_SEARCH;
          win_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
    endcase

    bitslip_d = (state_d == ST_SLIP);
    locked_d  = (state_d == ST_LOCKED);

    data_d = '0;
    ctl_d  = '0;
    de_d   = 1'b0;
    if (state_q == ST_LOCKED) begin
      if (is_token) begin
        ctl_d = token_code;
      end else begin
        de_d   = 1'b1;
        data_d = dec_data;
        ctl_d  = ctl_q;
      end
    end
  end

  // State, counters and registered outputs; reset aborts any slip in flight.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_SEARCH;
      run_q     <= '0;
      win_q     <= '0;
      settle_q  <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      data_q    <= '0;
      ctl_q     <= '0;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      win_q     <= win_d;
      settle_q  <= settle_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      data_q    <= data_d;
      ctl_q     <= ctl_d;
      de_q      <= de_d;
    end
  end

  assign tmds.bitSlip   = bitslip_q;
  assign tmds.locked    = locked_q;
  assign tmds.slipCount = slip_q;
  assign tmds.dataOut   = data_q;
  assign tmds.ctlOut    = ctl_q;
  assign tmds.deOut     = de_q;

endmodule
`default_nettype wire
